keypad_scanner: RTL and testbench

- Time-multiplexed 4x4 hex keypad scanner: the input-side counterpart of the team's multiplexed dual 7-segment display driver.
- Drives one keypad column low at a time and samples the four row lines.
- Debounces press and release, then emits a 4-bit hex key code with a one-cycle valid strobe.
- Sits between the board keypad pins and the display/digit-shift logic.

---
 rtl/keypad_scanner.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scanner with press/release debounce and hex encode.
// Latency: key_valid rises DEBOUNCE_CYCLES+1 clocks after the row sample that first sees a press.
// Backpressure: none; key_valid is a one-cycle strobe that the consumer must take when it fires.
// Optional feature macro KEYPAD_REPEAT_EN: extra key_valid every REPEAT_CYCLES while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,   // clocks per column before rows are sampled (>= 3)
    parameter int DEBOUNCE_CYCLES = 8,   // stable clocks to accept a press or a release (>= 2)
    parameter int REPEAT_CYCLES   = 32   // auto-repeat period, only with KEYPAD_REPEAT_EN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    // One counter serves both the column dwell and the debounce windows.
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic [1:0]    row_idx;
    logic [1:0]    row_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    key_nxt;
    logic          kv_nxt;
    logic          row_up;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_nxt;
`else
    // Repeat period has no effect in this build; keep it referenced for lint.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

    // Lowest-numbered low row wins when several rows are low in one column.
    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0]) begin
            idx = 2'd0;
        end else if (!r[1]) begin
            idx = 2'd1;
        end else if (!r[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Physical keypad legend, indexed by {row, column}.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    // The row line belonging to the key currently being tracked (1 = released).
    assign row_up = rs[row_idx];

    // Column drive: exactly one column low; frozen outside SCAN because col_idx only moves there.
    assign cols = ~(4'b0001 << col_idx);

    // HELD and RELEASE both mean the accepted key has not yet been cleanly let go.
    assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            cnt       <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            row_idx   <= row_nxt;
            cnt       <= cnt_nxt;
            key       <= key_nxt;
            key_valid <= kv_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_nxt;
`endif
        end
    end

    // Next-state and datapath updates; key_valid is a single-cycle pulse by default.
    always_comb begin
        state_nxt = state;
        col_nxt   = col_idx;
        row_nxt   = row_idx;
        cnt_nxt   = cnt;
        key_nxt   = key;
        kv_nxt    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt   = rep_cnt;
`endif
        case (state)
            ST_SCAN: begin
                // Sample only at the end of the dwell so the synchronizer has settled
                // on the rows of the column now driven.
                if (cnt == CW'(SCAN_DIV - 1)) begin
                    cnt_nxt = '0;
                    if (rs == 4'b1111) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        row_nxt   = low_row(rs);
                        state_nxt = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_DEBOUNCE: begin
                // cnt reaching DEBOUNCE_CYCLES means that many consecutive low samples.
                if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    key_nxt   = key_map(row_idx, col_idx);
                    kv_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else if (row_up) begin
                    // Bounce: drop the candidate and move on to the next column.
                    cnt_nxt   = '0;
                    col_nxt   = col_idx + 2'd1;
                    state_nxt = ST_SCAN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            ST_HELD: begin
                // Only the tracked row matters; other keys are ignored until release.
                if (row_up) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                    kv_nxt  = 1'b1;
                    rep_nxt = '0;
                end else begin
                    rep_nxt = rep_cnt + RW'(1);
                end
`endif
            end

            ST_RELEASE: begin
                if (!row_up) begin
                    // Release glitch: key is still down, no new strobe.
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    col_nxt   = col_idx + 2'd1;
                    state_nxt = ST_SCAN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = ST_SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed tests for keypad_scanner with a behavioural 4x4 key matrix.
// Latency: checks are made on the falling edge, cyc counts rising edges since reset release.
// Backpressure: not applicable; key_valid pulses are counted every cycle.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;      // bit r*4+c: key at row r, column c is down
    logic        raw_mode;     // 1: rows driven straight from raw_rows
    logic [3:0]  raw_rows;
    logic [3:0]  model_rows;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int kvn   = 0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        model_rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) model_rows[r] = 1'b0;
            end
        end
    end

    assign rows = raw_mode ? raw_rows : model_rows;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (key_valid === 1'b1) kvn++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] exp_cols;
        int k0;
        one      = 4'b0001;
        raw_mode = 1'b1;
        raw_rows = 4'b0000;
        pressed  = '0;
        reset    = 1'b1;
        repeat (3) tick();
        total++; if (cols !== 4'b1110) begin bad++; $display("FAIL reset_cols: got %b want 1110", cols); end
        total++; if (key !== 4'h0) begin bad++; $display("FAIL reset_key: got %h want 0", key); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
        raw_rows = 4'b1111;
        reset    = 1'b0;
        cyc      = 0;
        k0       = kvn;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_cols = ~(one << ((k / 4) % 4));
            total++;
            if (cols !== exp_cols) begin
                bad++; $display("FAIL scan_cols cyc%0d: got %b want %b", k, cols, exp_cols);
            end
        end
        total++; if (kvn - k0 !== 0) begin bad++; $display("FAIL scan_nostrobe: got %0d want 0", kvn - k0); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL scan_held: got %b want 0", key_held); end
        raw_mode = 1'b0;
    endtask

    task automatic test_press();
        int k0;
        pressed = '0;
        do_reset(2);
        k0 = kvn;
        pressed[1*4+2] = 1'b1;           // key 6
        run_to(20);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_early: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL press_held_early: got %b want 0", key_held); end
        run_to(21);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
        total++; if (key !== 4'h6) begin bad++; $display("FAIL press_key: got %h want 6", key); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press_held: got %b want 1", key_held); end
        total++; if (cols !== 4'b1011) begin bad++; $display("FAIL press_cols: got %b want 1011", cols); end
        run_to(22);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL press_pulse_len: got %b want 0", key_valid); end
        run_to(40);
        total++; if (cols !== 4'b1011) begin bad++; $display("FAIL press_frozen: got %b want 1011", cols); end
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL press_count: got %0d want 1", kvn - k0); end
    endtask

    task automatic test_bounce();
        int k0;
        pressed = '0;
        do_reset(2);
        k0 = kvn;
        pressed[3*4+1] = 1'b1;           // key 0
        run_to(10);
        pressed = '0;                    // seen by the FSM on its 5th debounce cycle
        run_to(13);
        total++; if (cols !== 4'b1011) begin bad++; $display("FAIL bounce_resume: got %b want 1011", cols); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b want 0", key_held); end
        total++; if (kvn - k0 !== 0) begin bad++; $display("FAIL bounce_nostrobe: got %0d want 0", kvn - k0); end
        pressed[3*4+1] = 1'b1;
        run_to(37);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL bounce2_early: got %b want 0", key_valid); end
        run_to(38);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL bounce2_valid: got %b want 1", key_valid); end
        total++; if (key !== 4'h0) begin bad++; $display("FAIL bounce2_key: got %h want 0", key); end
        total++; if (cols !== 4'b1101) begin bad++; $display("FAIL bounce2_cols: got %b want 1101", cols); end
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL bounce2_count: got %0d want 1", kvn - k0); end
    endtask

    task automatic test_release_glitch();
        int k0;
        pressed = '0;
        do_reset(2);
        k0 = kvn;
        pressed[1*4+1] = 1'b1;           // key 5
        run_to(17);
        total++; if (key_valid !== 1'b1 || key !== 4'h5) begin
            bad++; $display("FAIL glitch_accept: got valid=%b key=%h want 1/5", key_valid, key);
        end
        run_to(20);
        pressed = '0;                    // 3-cycle high glitch
        run_to(23);
        pressed[1*4+1] = 1'b1;
        run_to(24);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held_mid: got %b want 1", key_held); end
        run_to(26);
        pressed[0*4+1] = 1'b1;           // second key in the frozen column
        run_to(40);
        total++; if (key !== 4'h5) begin bad++; $display("FAIL glitch_key: got %h want 5", key); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL glitch_held: got %b want 1", key_held); end
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL glitch_count: got %0d want 1", kvn - k0); end
        pressed = '0;                    // clean release
        run_to(50);
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL release_early: got %b want 1", key_held); end
        run_to(51);
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_held: got %b want 0", key_held); end
        total++; if (key !== 4'h5) begin bad++; $display("FAIL release_key: got %h want 5", key); end
        total++; if (cols !== 4'b1011) begin bad++; $display("FAIL release_cols: got %b want 1011", cols); end
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL release_count: got %0d want 1", kvn - k0); end
    endtask

    task automatic test_multi_row();
        int k0;
        pressed = '0;
        do_reset(2);
        k0 = kvn;
        pressed[0*4+3] = 1'b1;           // key A
        pressed[2*4+3] = 1'b1;           // key C
        run_to(24);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL multi_early: got %b want 0", key_valid); end
        run_to(25);
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL multi_valid: got %b want 1", key_valid); end
        total++; if (key !== 4'hA) begin bad++; $display("FAIL multi_key: got %h want a", key); end
        run_to(35);
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL multi_count: got %0d want 1", kvn - k0); end
    endtask

    task automatic test_reset_midop();
        int k0;
        pressed = '0;
        do_reset(2);
        k0 = kvn;
        pressed[1*4+1] = 1'b1;           // key 5, debouncing from cycle 8
        run_to(11);
        reset = 1'b1;
        tick();
        total++; if (cols !== 4'b1110) begin bad++; $display("FAIL rstdb_cols: got %b want 1110", cols); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rstdb_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rstdb_held: got %b want 0", key_held); end
        tick();
        reset = 1'b0;
        cyc   = 0;
        total++; if (kvn - k0 !== 0) begin bad++; $display("FAIL rstdb_count: got %0d want 0", kvn - k0); end
        run_to(16);
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rstfresh_early: got %b want 0", key_valid); end
        run_to(17);
        total++; if (key_valid !== 1'b1 || key !== 4'h5) begin
            bad++; $display("FAIL rstfresh_accept: got valid=%b key=%h want 1/5", key_valid, key);
        end
        run_to(19);
        reset = 1'b1;                    // now in HELD
        tick();
        total++; if (cols !== 4'b1110) begin bad++; $display("FAIL rsthd_cols: got %b want 1110", cols); end
        total++; if (key !== 4'h0) begin bad++; $display("FAIL rsthd_key: got %h want 0", key); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL rsthd_valid: got %b want 0", key_valid); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rsthd_held: got %b want 0", key_held); end
        pressed = '0;
        tick();
        reset = 1'b0;
        cyc   = 0;
        run_to(20);
        total++; if (kvn - k0 !== 1) begin bad++; $display("FAIL rsthd_count: got %0d want 1", kvn - k0); end
        total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rsthd_after: got %b want 0", key_held); end
    endtask

    task automatic test_hold_repeat();
        int k0;
        int exp_rep;
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 3;                     // pulses 32, 64 and 96 cycles after accept
`else
        exp_rep = 0;
`endif
        pressed = '0;
        do_reset(2);
        pressed[2*4+2] = 1'b1;           // key 9
        run_to(21);
        total++; if (key_valid !== 1'b1 || key !== 4'h9) begin
            bad++; $display("FAIL hold_accept: got valid=%b key=%h want 1/9", key_valid, key);
        end
        k0 = kvn;
        run_to(121);
        total++; if (kvn - k0 !== exp_rep) begin bad++; $display("FAIL hold_repeats: got %0d want %0d", kvn - k0, exp_rep); end
        total++; if (key !== 4'h9) begin bad++; $display("FAIL hold_key: got %h want 9", key); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL hold_held: got %b want 1", key_held); end
        pressed = '0;
    endtask

    initial begin
        reset    = 1'b1;
        raw_mode = 1'b1;
        raw_rows = 4'b0000;
        pressed  = '0;
        test_reset();
        test_press();
        test_bounce();
        test_release_glitch();
        test_multi_row();
        test_reset_midop();
        test_hold_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
